// File: rtl/spi_mem_pkg.sv
// Shared types for the SPI memory slave: FSM states and command codes.
package spi_mem_pkg;

   typedef enum logic [3:0] {
      IDLE,
      RW,
      CMD,
      WR_ADDR,
      WR_DATA,
      RD_ADDR,
      RD_DUMMY,
      RD_SHIFT,
      ERR
   } spi_state_t;

   localparam logic [1:0] CMD_WR_ADDR = 2'b00;
   localparam logic [1:0] CMD_WR_DATA = 2'b01;
   localparam logic [1:0] CMD_RD_ADDR = 2'b10;
   localparam logic [1:0] CMD_RD_DATA = 2'b11;

endpackage

// File: rtl/spi_mem_ram.sv
// Single-port word RAM; the read word is captured by the caller's tx
// register on the load edge, so the read path here is address-combinational.
module spi_mem_ram #(
   parameter int DATA_W    = 8,
   parameter int ADDR_W    = 8,
   parameter int MEM_DEPTH = 256
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] din,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem_q [MEM_DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[addr] <= din;
      end
   end

   assign rdata = mem_q[addr];

endmodule

// File: rtl/spi_mem_slave_p.sv
// SPI slave with on-chip RAM: address/data commands, burst auto-increment,
// and direction/command consistency checking with an error pulse.
module spi_mem_slave_p
   import spi_mem_pkg::*;
#(
   parameter int DATA_W    = 8,
   parameter int ADDR_W    = 8,
   parameter int MEM_DEPTH = 256,
   parameter int AUTO_INC  = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic ss_n,
   input  logic mosi,
   output logic miso,
   output logic frame_err
);

   localparam int CNT_W = $clog2(DATA_W + 1);
   localparam logic [ADDR_W-1:0] LAST   = ADDR_W'(MEM_DEPTH - 1);
   localparam logic [CNT_W-1:0]  D_LAST = CNT_W'(DATA_W - 1);
   localparam logic [CNT_W-1:0]  A_LAST = CNT_W'(ADDR_W - 1);

   spi_state_t        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              rw_q, rw_d;
   logic              cmd0_q, cmd0_d;
   logic [DATA_W-1:0] rx_q, rx_d;
   logic [DATA_W-1:0] tx_q, tx_d;
   logic [ADDR_W-1:0] wr_q, wr_d;
   logic [ADDR_W-1:0] rd_q, rd_d;
   logic              err_q, err_d;

   logic [DATA_W-1:0] rx_nxt;
   logic [DATA_W-1:0] rdata;
   logic [ADDR_W-1:0] addr_in;
   logic [ADDR_W-1:0] wr_inc;
   logic [ADDR_W-1:0] rd_inc;
   logic [ADDR_W-1:0] ram_addr;
   logic [1:0]        cmd;
   logic              we;
   logic              ram_we;

   assign rx_nxt  = {rx_q[DATA_W-2:0], mosi};
   assign addr_in = ADDR_W'(32'(rx_nxt[ADDR_W-1:0]) % MEM_DEPTH);
   assign wr_inc  = (wr_q == LAST) ? '0 : wr_q + 1'b1;
   assign rd_inc  = (rd_q == LAST) ? '0 : rd_q + 1'b1;
   assign cmd     = {cmd0_q, mosi};

   // In RD_SHIFT the only RAM read is the next burst word.
   assign ram_addr = (state_q == RD_SHIFT) ? rd_inc :
                     (state_q == WR_DATA)  ? wr_q   : rd_q;
   assign ram_we   = we & ~rst;

   spi_mem_ram #(
      .DATA_W    (DATA_W),
      .ADDR_W    (ADDR_W),
      .MEM_DEPTH (MEM_DEPTH)
   ) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .addr  (ram_addr),
      .din   (rx_nxt),
      .rdata (rdata)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rw_d    = rw_q;
      cmd0_d  = cmd0_q;
      rx_d    = rx_q;
      tx_d    = tx_q;
      wr_d    = wr_q;
      rd_d    = rd_q;
      err_d   = 1'b0;
      we      = 1'b0;
      if (ss_n) begin
         state_d = IDLE;
         cnt_d   = '0;
         tx_d    = '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               state_d = RW;
               cnt_d   = '0;
            end
            RW: begin
               rw_d    = mosi;
               state_d = CMD;
            end
            CMD: begin
               cmd0_d = mosi;
               cnt_d  = cnt_q + 1'b1;
               if (cnt_q != '0) begin
                  cnt_d = '0;
                  if (rw_q != cmd[1]) begin
                     state_d = ERR;
                     err_d   = 1'b1;
                  end else begin
                     unique case (cmd)
                        CMD_WR_ADDR: state_d = WR_ADDR;
                        CMD_WR_DATA: state_d = WR_DATA;
                        CMD_RD_ADDR: state_d = RD_ADDR;
                        CMD_RD_DATA: state_d = RD_DUMMY;
                     endcase
                  end
               end
            end
            // ERR also serves as the sink for bits after a finished frame.
            WR_ADDR: begin
               rx_d  = rx_nxt;
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == A_LAST) begin
                  wr_d    = addr_in;
                  state_d = ERR;
               end
            end
            RD_ADDR: begin
               rx_d  = rx_nxt;
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == A_LAST) begin
                  rd_d    = addr_in;
                  state_d = ERR;
               end
            end
            WR_DATA: begin
               rx_d  = rx_nxt;
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == D_LAST) begin
                  we    = 1'b1;
                  cnt_d = '0;
                  if (AUTO_INC != 0) wr_d = wr_inc;
                  else state_d = ERR;
               end
            end
            RD_DUMMY: begin
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == D_LAST) begin
                  tx_d    = rdata;
                  cnt_d   = '0;
                  state_d = RD_SHIFT;
               end
            end
            RD_SHIFT: begin
               tx_d  = tx_q << 1;
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == D_LAST) begin
                  cnt_d = '0;
                  if (AUTO_INC != 0) begin
                     rd_d = rd_inc;
                     tx_d = rdata;
                  end else begin
                     tx_d    = '0;
                     state_d = ERR;
                  end
               end
            end
            ERR: ;
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         rw_q    <= 1'b0;
         cmd0_q  <= 1'b0;
         rx_q    <= '0;
         tx_q    <= '0;
         wr_q    <= '0;
         rd_q    <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rw_q    <= rw_d;
         cmd0_q  <= cmd0_d;
         rx_q    <= rx_d;
         tx_q    <= tx_d;
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         err_q   <= err_d;
      end
   end

   assign miso      = tx_q[DATA_W-1];
   assign frame_err = err_q;

endmodule

// File: tb/tb_spi_mem_slave_p.sv
// Bench for spi_mem_slave_p: three configurations checked against a
// frame-level memory/pointer model, plus reset corner sequences.
module tb_spi_mem_slave_p;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [2:0] ss_n = 3'b111;
   logic [2:0] mosi = 3'b000;
   logic       miso0, miso1, miso2;
   logic       ferr0, ferr1, ferr2;

   always #5 clk = ~clk;

   spi_mem_slave_p u0 (
      .clk(clk), .rst(rst), .ss_n(ss_n[0]), .mosi(mosi[0]),
      .miso(miso0), .frame_err(ferr0)
   );

   spi_mem_slave_p #(
      .DATA_W(16), .ADDR_W(4), .MEM_DEPTH(10), .AUTO_INC(1)
   ) u1 (
      .clk(clk), .rst(rst), .ss_n(ss_n[1]), .mosi(mosi[1]),
      .miso(miso1), .frame_err(ferr1)
   );

   spi_mem_slave_p #(.AUTO_INC(0)) u2 (
      .clk(clk), .rst(rst), .ss_n(ss_n[2]), .mosi(mosi[2]),
      .miso(miso2), .frame_err(ferr2)
   );

   int dw  [3] = '{8, 16, 8};
   int aw  [3] = '{8, 4, 8};
   int dep [3] = '{256, 10, 256};
   int ai  [3] = '{1, 1, 0};

   int          wr_m [3];
   int          rd_m [3];
   logic [15:0] mem_m [3][256];
   bit          mem_v [3][256];

   int n_chk = 0;
   int n_err = 0;

   typedef struct {
      int          u;
      bit          rw;
      bit [1:0]    cmd;
      int          n;
      logic [63:0] pl;
      bit          xerr;
      bit          has_x;
      logic [63:0] xdata;
   } vec_t;

   vec_t tbl[$];

   function automatic logic miso_of(input int u);
      return (u == 0) ? miso0 : (u == 1) ? miso1 : miso2;
   endfunction

   function automatic logic ferr_of(input int u);
      return (u == 0) ? ferr0 : (u == 1) ? ferr1 : ferr2;
   endfunction

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   // Expected miso after edge e of a frame, from stored words and pointer.
   task automatic exp_bit(input int u, input bit isrd, input int e,
                          output logic xm, output bit known);
      int d = dw[u];
      int j = e - 3 - d;
      int w, a;
      known = 1'b1;
      xm    = 1'b0;
      if (!isrd || j < 0) return;
      w = j / d;
      if (ai[u] == 0 && w >= 1) return;
      a = (rd_m[u] + w) % dep[u];
      if (!mem_v[u][a]) begin
         known = 1'b0;
         return;
      end
      xm = mem_m[u][a][d - 1 - (j % d)];
   endtask

   function automatic void upd(input int u, input bit rw,
                               input bit [1:0] cmd, input int n,
                               input logic [63:0] pl);
      int d = dw[u];
      int a = aw[u];
      int k;
      logic [63:0] amask = (64'd1 << a) - 1;
      logic [63:0] dmask = (64'd1 << d) - 1;
      if (rw != cmd[1]) return;
      case (cmd)
         2'b00: if (n >= a) wr_m[u] = int'((pl >> (n - a)) & amask) % dep[u];
         2'b10: if (n >= a) rd_m[u] = int'((pl >> (n - a)) & amask) % dep[u];
         2'b01: begin
            k = n / d;
            if (ai[u] == 0 && k > 1) k = 1;
            for (int w = 0; w < k; w++) begin
               mem_m[u][wr_m[u]] = 16'((pl >> (n - (w + 1) * d)) & dmask);
               mem_v[u][wr_m[u]] = 1'b1;
               if (ai[u] != 0) wr_m[u] = (wr_m[u] + 1) % dep[u];
            end
         end
         default: if (ai[u] != 0 && n >= d)
            rd_m[u] = (rd_m[u] + (n - d) / d) % dep[u];
      endcase
   endfunction

   task automatic run_frame(input int u, input bit rw, input bit [1:0] cmd,
                            input int n, input logic [63:0] pl,
                            input bit xerr, input bit has_x,
                            input logic [63:0] xdata);
      bit          isrd = (rw == cmd[1]) && (cmd == 2'b11);
      int          last = 3 + n;
      logic [63:0] got  = '0;
      logic        b, xm;
      bit          known;
      for (int e = 0; e <= last; e++) begin
         if (e == 0) b = ~rw;
         else if (e == 1) b = rw;
         else if (e == 2) b = cmd[1];
         else if (e == 3) b = cmd[0];
         else b = pl[n - 1 - (e - 4)];
         ss_n[u] = 1'b0;
         mosi[u] = b;
         tick();
         chk($sformatf("u%0d e%0d frame_err", u, e),
             64'(ferr_of(u)), 64'(e == 3 && xerr));
         exp_bit(u, isrd, e, xm, known);
         if (known)
            chk($sformatf("u%0d e%0d miso", u, e), 64'(miso_of(u)), 64'(xm));
         if (isrd && e >= 3 + dw[u] && e < last)
            got = {got[62:0], miso_of(u)};
      end
      ss_n[u] = 1'b1;
      mosi[u] = 1'b0;
      tick();
      chk($sformatf("u%0d end miso", u), 64'(miso_of(u)), 64'd0);
      chk($sformatf("u%0d end frame_err", u), 64'(ferr_of(u)), 64'd0);
      if (has_x) chk($sformatf("u%0d read data", u), got, xdata);
      upd(u, rw, cmd, n, pl);
   endtask

   function automatic vec_t mk(input int u, input bit rw, input bit [1:0] c,
                               input int n, input logic [63:0] pl,
                               input bit xerr, input bit hx,
                               input logic [63:0] xd);
      vec_t v;
      v.u = u; v.rw = rw; v.cmd = c; v.n = n; v.pl = pl;
      v.xerr = xerr; v.has_x = hx; v.xdata = xd;
      return v;
   endfunction

   initial begin
      logic        xm;
      bit          known;
      bit [1:0]    c;
      bit          rw;
      int          u, n;
      logic [63:0] pl;

      tbl.push_back(mk(0, 0, 2'b00,  8, 64'h65, 0, 0, 0));
      tbl.push_back(mk(0, 0, 2'b01,  8, 64'hA6, 0, 0, 0));
      tbl.push_back(mk(0, 1, 2'b10,  8, 64'h65, 0, 0, 0));
      tbl.push_back(mk(0, 1, 2'b11, 16, 64'h0,  0, 1, 64'hA6));
      tbl.push_back(mk(0, 0, 2'b00,  8, 64'hFE, 0, 0, 0));
      tbl.push_back(mk(0, 0, 2'b01, 24, 64'h112233, 0, 0, 0));
      tbl.push_back(mk(0, 1, 2'b10,  8, 64'hFE, 0, 0, 0));
      tbl.push_back(mk(0, 1, 2'b11, 32, 64'h0,  0, 1, 64'h112233));
      tbl.push_back(mk(0, 0, 2'b01,  8, 64'h5A, 0, 0, 0));
      tbl.push_back(mk(0, 0, 2'b10,  8, 64'hFE, 1, 0, 0));
      tbl.push_back(mk(0, 1, 2'b11, 16, 64'h0,  0, 1, 64'h5A));
      tbl.push_back(mk(0, 0, 2'b00,  8, 64'h01, 0, 0, 0));
      tbl.push_back(mk(0, 1, 2'b01,  8, 64'hC3, 1, 0, 0));
      tbl.push_back(mk(0, 1, 2'b10,  8, 64'h01, 0, 0, 0));
      tbl.push_back(mk(0, 1, 2'b11, 16, 64'h0,  0, 1, 64'h5A));
      tbl.push_back(mk(0, 0, 2'b00,  8, 64'h65, 0, 0, 0));
      tbl.push_back(mk(0, 0, 2'b01,  5, 64'h1F, 0, 0, 0));
      tbl.push_back(mk(0, 1, 2'b10,  8, 64'h65, 0, 0, 0));
      tbl.push_back(mk(0, 1, 2'b11, 16, 64'h0,  0, 1, 64'hA6));
      tbl.push_back(mk(0, 0, 2'b01,  8, 64'h3C, 0, 0, 0));
      tbl.push_back(mk(0, 1, 2'b10,  8, 64'h65, 0, 0, 0));
      tbl.push_back(mk(0, 1, 2'b11, 12, 64'h0,  0, 0, 0));
      tbl.push_back(mk(0, 1, 2'b11, 16, 64'h0,  0, 1, 64'h3C));
      tbl.push_back(mk(1, 0, 2'b00,  4, 64'hC,  0, 0, 0));
      tbl.push_back(mk(1, 0, 2'b01, 16, 64'hBEEF, 0, 0, 0));
      tbl.push_back(mk(1, 1, 2'b10,  4, 64'h2,  0, 0, 0));
      tbl.push_back(mk(1, 1, 2'b11, 32, 64'h0,  0, 1, 64'hBEEF));
      tbl.push_back(mk(1, 0, 2'b00,  4, 64'h9,  0, 0, 0));
      tbl.push_back(mk(1, 0, 2'b01, 32, 64'h12345678, 0, 0, 0));
      tbl.push_back(mk(1, 1, 2'b10,  4, 64'h9,  0, 0, 0));
      tbl.push_back(mk(1, 1, 2'b11, 48, 64'h0,  0, 1, 64'h12345678));
      tbl.push_back(mk(2, 0, 2'b00,  8, 64'h10, 0, 0, 0));
      tbl.push_back(mk(2, 0, 2'b01, 16, 64'hA55A, 0, 0, 0));
      tbl.push_back(mk(2, 1, 2'b10,  8, 64'h10, 0, 0, 0));
      tbl.push_back(mk(2, 1, 2'b11, 24, 64'h0,  0, 1, 64'hA500));
      tbl.push_back(mk(2, 0, 2'b01,  8, 64'h42, 0, 0, 0));
      tbl.push_back(mk(2, 1, 2'b11, 16, 64'h0,  0, 1, 64'h42));

      for (int i = 0; i < 3; i++) begin
         wr_m[i] = 0;
         rd_m[i] = 0;
      end

      repeat (2) tick();
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("u%0d reset miso", i), 64'(miso_of(i)), 64'd0);
         chk($sformatf("u%0d reset frame_err", i), 64'(ferr_of(i)), 64'd0);
      end
      rst = 1'b0;
      tick();

      foreach (tbl[i])
         run_frame(tbl[i].u, tbl[i].rw, tbl[i].cmd, tbl[i].n, tbl[i].pl,
                   tbl[i].xerr, tbl[i].has_x, tbl[i].xdata);

      // Reset in the middle of a read word.
      run_frame(0, 1, 2'b10, 8, 64'h65, 0, 0, 0);
      ss_n[0] = 1'b0;
      for (int e = 0; e <= 14; e++) begin
         mosi[0] = (e >= 1 && e <= 3);
         tick();
      end
      exp_bit(0, 1'b1, 14, xm, known);
      if (known) chk("u0 pre-reset miso", 64'(miso0), 64'(xm));
      rst = 1'b1;
      tick();
      chk("u0 miso after mid-read reset", 64'(miso0), 64'd0);
      rst = 1'b0;
      ss_n[0] = 1'b1;
      tick();
      chk("u0 miso idle after reset", 64'(miso0), 64'd0);
      for (int i = 0; i < 3; i++) begin
         wr_m[i] = 0;
         rd_m[i] = 0;
      end
      run_frame(0, 1, 2'b11, 16, 64'h0, 0, 1, 64'h33);
      run_frame(1, 0, 2'b01, 16, 64'hCAFE, 0, 0, 0);
      run_frame(1, 1, 2'b11, 32, 64'h0, 0, 1, 64'hCAFE);

      // Reset and ss_n falling on the same edge: reset wins.
      rst = 1'b1;
      ss_n[0] = 1'b0;
      mosi[0] = 1'b1;
      tick();
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         wr_m[i] = 0;
         rd_m[i] = 0;
      end
      run_frame(0, 1, 2'b10, 8, 64'h65, 0, 0, 0);
      run_frame(0, 1, 2'b11, 16, 64'h0, 0, 1, 64'h3C);

      for (int i = 0; i < 60; i++) begin
         u  = $urandom_range(0, 2);
         c  = 2'($urandom);
         rw = ($urandom_range(0, 3) == 0) ? ~c[1] : c[1];
         n  = $urandom_range(0, 4 * dw[u]);
         pl = {$urandom, $urandom};
         run_frame(u, rw, c, n, pl, rw != c[1], 0, 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
